// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: in-order writeback has priority, long-latency
// results wait in a small FIFO and are forced through after too many lost slots.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_en,
    input  logic [5:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        lu_valid,
    input  logic [5:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        lu_ready,
    input  logic [5:0]  chk_addr,
    output logic        chk_pending,
    output logic        rf_we,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    LIMIT    = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_WAIT,
        ST_FORCE
    } state_t;

    state_t         state;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [7:0]     starve;
    logic [7:0]     starve_inc;

    logic [5:0]     addr_mem [DEPTH];
    logic [31:0]    data_mem [DEPTH];
    logic [5:0]     head_addr;
    logic [31:0]    head_data;

    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           grant_pipe;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign lu_ready   = !full;
    assign push       = lu_valid && !full;
    assign pipe_stall = (state == ST_FORCE);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign starve_inc = (starve == LIMIT) ? starve : starve + 8'd1;

    always_comb begin
        grant_pipe = 1'b0;
        pop        = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                grant_pipe = pipe_en;
            end
            ST_WAIT: begin
                grant_pipe = pipe_en;
                pop        = !pipe_en && !empty;
            end
            ST_FORCE: begin
                pop = !empty;
            end
            default: begin
                grant_pipe = 1'b0;
                pop        = 1'b0;
            end
        endcase
    end

    // The head leaving this cycle is already on its way to rf_*.
    always_comb begin
        chk_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && !((i == 0) && pop) &&
                (addr_mem[rd_ptr + AW'(i)] == chk_addr)) begin
                chk_pending = 1'b1;
            end
        end
        if (chk_addr == '0) begin
            chk_pending = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= lu_waddr;
            data_mem[wr_ptr] <= lu_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_EMPTY;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            starve   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            rf_we <= 1'b0;
            if (grant_pipe) begin
                rf_we    <= (pipe_waddr != '0);
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end else if (pop) begin
                rf_we    <= (head_addr != '0);
                rf_waddr <= head_addr;
                rf_wdata <= head_data;
            end

            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        starve <= '0;
                        if (count_nxt == '0) begin
                            state <= ST_EMPTY;
                        end
                    end else if (pipe_en) begin
                        starve <= starve_inc;
                        if (starve_inc == LIMIT) begin
                            state <= ST_FORCE;
                        end
                    end
                end
                ST_FORCE: begin
                    starve <= '0;
                    state  <= (count_nxt == '0) ? ST_EMPTY : ST_WAIT;
                end
                default: begin
                    starve <= '0;
                    state  <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected rf writes go into a queue,
// a negedge monitor pops and compares every rf_we pulse.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pipe_en;
    logic [5:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        lu_valid;
    logic [5:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [5:0]  chk_addr;
    logic        chk_pending;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk),
        .resetn(resetn),
        .pipe_en(pipe_en),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .lu_valid(lu_valid),
        .lu_waddr(lu_waddr),
        .lu_wdata(lu_wdata),
        .lu_ready(lu_ready),
        .chk_addr(chk_addr),
        .chk_pending(chk_pending),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rf_write_unexpected: got addr %0d data %h, expected no write",
                         rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_waddr !== mon_e.a || rf_wdata !== mon_e.d) begin
                    n_err++;
                    $display("FAIL rf_write: got addr %0d data %h, expected addr %0d data %h",
                             rf_waddr, rf_wdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic drive(input logic pe, input logic [5:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [5:0] la, input logic [31:0] ld,
                         input logic [5:0] ca);
        pipe_en    = pe;
        pipe_waddr = pa;
        pipe_wdata = pd;
        lu_valid   = lv;
        lu_waddr   = la;
        lu_wdata   = ld;
        chk_addr   = ca;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset state
        mid();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_lu_ready", lu_ready, 1);
        chk("reset_pipe_stall", pipe_stall, 0);
        chk("reset_chk_pending", chk_pending, 0);
        resetn = 1'b1;
        nxt();

        // plain pipe write
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        expect_wr(5, 32'hDEADBEEF);
        mid();
        chk("pipe_stall_idle", pipe_stall, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        mid();
        nxt();

        // pending flag over the lifetime of one buffered result
        drive(0, 0, 0, 1, 9, 32'h1234, 9);
        mid();
        chk("pend_on_push", chk_pending, 0);
        chk("lu_ready_empty", lu_ready, 1);
        nxt();
        drive(1, 7, 32'h77, 0, 0, 0, 9);
        expect_wr(7, 32'h77);
        mid();
        chk("pend_buffered", chk_pending, 1);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 9);
        expect_wr(9, 32'h1234);
        mid();
        chk("pend_popping", chk_pending, 0);
        nxt();
        mid();
        chk("pend_after_pop", chk_pending, 0);
        nxt();

        // starvation forces a drain after 8 denied cycles
        drive(0, 0, 0, 1, 3, 32'h3333, 0);
        mid();
        nxt();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 6'(16 + i), 32'hA000 + i, 0, 0, 0, 0);
            expect_wr(6'(16 + i), 32'hA000 + i);
            mid();
            chk("stall_before_limit", pipe_stall, 0);
            nxt();
        end
        drive(1, 40, 32'hB0B0, 0, 0, 0, 0);
        expect_wr(3, 32'h3333);
        mid();
        chk("stall_force", pipe_stall, 1);
        nxt();
        expect_wr(40, 32'hB0B0);
        mid();
        chk("stall_after_force", pipe_stall, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        mid();
        nxt();

        // fill the FIFO behind a busy pipe, refuse a fifth result, drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'(50 + i), 32'hC0 + i, 1, 6'(10 + i), 32'hD0 + i, 0);
            expect_wr(6'(50 + i), 32'hC0 + i);
            mid();
            chk("lu_ready_filling", lu_ready, 1);
            nxt();
        end
        drive(1, 54, 32'hC4, 1, 20, 32'hBAD, 0);
        expect_wr(54, 32'hC4);
        mid();
        chk("lu_ready_full", lu_ready, 0);
        nxt();
        drive(0, 0, 0, 1, 20, 32'hBAD, 0);
        expect_wr(10, 32'hD0);
        mid();
        chk("lu_ready_full_pop", lu_ready, 0);
        nxt();
        drive(0, 0, 0, 0, 0, 0, 0);
        expect_wr(11, 32'hD1);
        mid();
        chk("lu_ready_after_pop", lu_ready, 1);
        nxt();
        expect_wr(12, 32'hD2);
        mid();
        nxt();
        expect_wr(13, 32'hD3);
        mid();
        nxt();
        mid();
        nxt();

        // address 0 is never written, then reset drops buffered results
        drive(1, 0, 32'hFFFF, 1, 30, 32'h30, 0);
        mid();
        nxt();
        drive(1, 0, 32'hFFFF, 1, 0, 32'h31, 30);
        mid();
        chk("addr0_no_we", rf_we, 0);
        chk("pend_entry30", chk_pending, 1);
        nxt();
        drive(1, 0, 32'hFFFF, 0, 0, 0, 0);
        mid();
        chk("pend_addr0", chk_pending, 0);
        nxt();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 30);
        mid();
        chk("rst_mid_pending", chk_pending, 0);
        chk("rst_mid_lu_ready", lu_ready, 1);
        chk("rst_mid_rf_we", rf_we, 0);
        chk("rst_mid_stall", pipe_stall, 0);
        resetn = 1'b1;
        nxt();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("post_rst_rf_we", rf_we, 0);
            chk("post_rst_pending", chk_pending, 0);
            nxt();
        end

        chk("writes_outstanding", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
